// File: rtl/data_sram_responder_pkg.sv
// Shared memory map for data_sram_responder: MMIO base/offsets, width defaults,
// MMIO register decode and the byte-lane merge used by RAM-style partial writes.
package data_sram_responder_pkg;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hBFAF_0000;
    localparam int          DEFAULT_LED_W     = 16;
    localparam int          DEFAULT_SW_W      = 8;

    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_SWITCH  = 16'h0004;
    localparam logic [15:0] OFF_TIMER   = 16'h0008;
    localparam logic [15:0] OFF_SCRATCH = 16'h000C;

    typedef enum logic [2:0] {
        REG_LED,
        REG_SWITCH,
        REG_TIMER,
        REG_SCRATCH,
        REG_NONE
    } mmio_reg_e;

    // Decode on the word offset only; byte-offset bits never select a register.
    function automatic mmio_reg_e decode_mmio(input logic [13:0] word_off);
        mmio_reg_e sel;
        sel = REG_NONE;
        if (word_off == OFF_LED[15:2])          sel = REG_LED;
        else if (word_off == OFF_SWITCH[15:2])  sel = REG_SWITCH;
        else if (word_off == OFF_TIMER[15:2])   sel = REG_TIMER;
        else if (word_off == OFF_SCRATCH[15:2]) sel = REG_SCRATCH;
        return sel;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  wen);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = wen[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// SRAM-style data port between the core (master) and the memory responder (slave).
interface data_sram_responder_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output en, output wen, output addr, output wdata, input rdata);
    modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/data_sram_responder_spram_be.sv
// Single-port 2^ADDR_W x 32 RAM with per-byte write enables and a registered read
// that only updates on a read strobe, so its output holds between reads.
module data_sram_responder_spram_be #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    // One byte-wide array per lane keeps each lane a plain inferable block RAM.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rdata_reg;

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    mem[addr] <= wdata[8*gi +: 8];
                end
                if (rd_en) begin
                    rdata_reg <= mem[addr];
                end
            end

            assign rdata[8*gi +: 8] = rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/data_sram_responder.sv
// Data-port responder: word RAM plus LED/switch/scratch/timer MMIO window, read latency 1.
// Optional free-running timer at offset 0x0008 enabled by defining CONF_TIMER_EN.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int          ADDR_W    = 14,
    parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE,
    parameter int          LED_W     = DEFAULT_LED_W,
    parameter int          SW_W      = DEFAULT_SW_W
) (
    input  logic                  clk,
    input  logic                  rst,
    data_sram_responder_if.slave  sram,
    output logic [LED_W-1:0]      led,
    input  logic [SW_W-1:0]       switch_in
);

    logic        is_mmio;
    logic        rd_req;
    logic        wr_req;
    mmio_reg_e   mmio_sel;
    logic [31:0] ram_rdata;
    logic [31:0] mmio_rdata_next;
    logic [31:0] led_merged;
    logic [31:0] timer_word;
    logic        unused_bits;

    logic             sel_ram_reg;
    logic [31:0]      mmio_rdata_reg;
    logic [LED_W-1:0] led_reg;
    logic [31:0]      scratch_reg;
    logic [SW_W-1:0]  sw_meta_reg;
    logic [SW_W-1:0]  sw_sync_reg;

    assign is_mmio    = (sram.addr[31:16] == MMIO_BASE[31:16]);
    assign rd_req     = sram.en && (sram.wen == 4'b0000);
    assign wr_req     = sram.en && (sram.wen != 4'b0000);
    assign mmio_sel   = decode_mmio(sram.addr[15:2]);
    assign led_merged = merge_bytes(32'(led_reg), sram.wdata, sram.wen);
    assign unused_bits = ^{sram.addr[1:0], led_merged[31:LED_W]};

    data_sram_responder_spram_be #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .rd_en (rd_req && !is_mmio),
        .we    ((sram.en && !is_mmio) ? sram.wen : 4'b0000),
        .addr  (sram.addr[ADDR_W+1:2]),
        .wdata (sram.wdata),
        .rdata (ram_rdata)
    );

`ifdef CONF_TIMER_EN
    logic [31:0] timer_reg;

    assign timer_word = timer_reg;

    // A TIMER write wins over the increment in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_reg <= '0;
        end else if (wr_req && is_mmio && mmio_sel == REG_TIMER) begin
            timer_reg <= merge_bytes(timer_reg, sram.wdata, sram.wen);
        end else begin
            timer_reg <= timer_reg + 32'd1;
        end
    end
`else
    assign timer_word = 32'h0;
`endif

    always_comb begin
        mmio_rdata_next = 32'h0;
        case (mmio_sel)
            REG_LED:     mmio_rdata_next = 32'(led_reg);
            REG_SWITCH:  mmio_rdata_next = 32'(sw_sync_reg);
            REG_TIMER:   mmio_rdata_next = timer_word;
            REG_SCRATCH: mmio_rdata_next = scratch_reg;
            default:     mmio_rdata_next = 32'h0;
        endcase
    end

    // Read mux state only moves on a read, so rdata holds across writes and idles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_ram_reg    <= 1'b0;
            mmio_rdata_reg <= '0;
            led_reg        <= '0;
            scratch_reg    <= '0;
            sw_meta_reg    <= '0;
            sw_sync_reg    <= '0;
        end else begin
            sw_meta_reg <= switch_in;
            sw_sync_reg <= sw_meta_reg;
            if (rd_req) begin
                sel_ram_reg <= !is_mmio;
                if (is_mmio) begin
                    mmio_rdata_reg <= mmio_rdata_next;
                end
            end
            if (wr_req && is_mmio) begin
                case (mmio_sel)
                    REG_LED:     led_reg     <= led_merged[LED_W-1:0];
                    REG_SCRATCH: scratch_reg <= merge_bytes(scratch_reg, sram.wdata, sram.wen);
                    default:     ;
                endcase
            end
        end
    end

    assign sram.rdata = sel_ram_reg ? ram_rdata : mmio_rdata_reg;
    assign led        = led_reg;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: a vector table for RAM/MMIO traffic plus
// hand sequences for LED, switch sync, timer and mid-stream reset.
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] led;
    logic [7:0]  switch_in;

    int n_checks = 0;
    int n_errors = 0;

    data_sram_responder_if sram_bus ();

    data_sram_responder dut (
        .clk       (clk),
        .rst       (rst),
        .sram      (sram_bus),
        .led       (led),
        .switch_in (switch_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    // Drive one request, let one rising edge pass, return 1 time unit later.
    task automatic req(input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
        sram_bus.en    = en;
        sram_bus.wen   = wen;
        sram_bus.addr  = addr;
        sram_bus.wdata = wdata;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0040, 32'h1234_5678, 32'h0000_0000};
        vecs[1]  = '{1'b1, 4'h0, 32'h0000_0040, 32'h0000_0000, 32'h1234_5678};
        vecs[2]  = '{1'b0, 4'hF, 32'h0000_0040, 32'h0000_0000, 32'h1234_5678};
        vecs[3]  = '{1'b0, 4'hF, 32'h0000_0040, 32'h0000_0000, 32'h1234_5678};
        vecs[4]  = '{1'b0, 4'h0, 32'h0000_0040, 32'h0000_0000, 32'h1234_5678};
        vecs[5]  = '{1'b1, 4'h0, 32'h0000_0040, 32'h0000_0000, 32'h1234_5678};
        vecs[6]  = '{1'b1, 4'hF, 32'h0000_0080, 32'h1111_1111, 32'h1234_5678};
        vecs[7]  = '{1'b1, 4'h5, 32'h0000_0080, 32'hAABB_CCDD, 32'h1234_5678};
        vecs[8]  = '{1'b1, 4'h0, 32'h0000_0080, 32'h0000_0000, 32'h11BB_11DD};
        vecs[9]  = '{1'b1, 4'hF, 32'hBFAF_000C, 32'hDEAD_BEEF, 32'h11BB_11DD};
        vecs[10] = '{1'b1, 4'h1, 32'hBFAF_000C, 32'h0000_0012, 32'h11BB_11DD};
        vecs[11] = '{1'b1, 4'h0, 32'hBFAF_000C, 32'h0000_0000, 32'hDEAD_BE12};
        vecs[12] = '{1'b1, 4'h0, 32'hBFAF_0010, 32'h0000_0000, 32'h0000_0000};
        vecs[13] = '{1'b1, 4'hF, 32'hBFAF_0010, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[14] = '{1'b1, 4'h0, 32'hBFAF_0010, 32'h0000_0000, 32'h0000_0000};
        vecs[15] = '{1'b1, 4'h0, 32'h0001_0040, 32'h0000_0000, 32'h1234_5678};
        vecs[16] = '{1'b1, 4'h0, 32'hBFAF_100C, 32'h0000_0000, 32'h0000_0000};

        rst            = 1'b1;
        switch_in      = 8'h00;
        sram_bus.en    = 1'b0;
        sram_bus.wen   = 4'h0;
        sram_bus.addr  = 32'h0;
        sram_bus.wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", sram_bus.rdata, 32'h0);
        check("reset_led", 32'(led), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            req(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_rdata", i), sram_bus.rdata, vecs[i].exp_rdata);
        end

        // LED register: full write, readback, partial lane write
        req(1'b1, 4'hF, 32'hBFAF_0000, 32'hFFFF_A5A5);
        check("led_after_write", 32'(led), 32'h0000_A5A5);
        req(1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
        check("led_readback", sram_bus.rdata, 32'h0000_A5A5);
        req(1'b1, 4'h2, 32'hBFAF_0000, 32'h0000_3C00);
        check("led_lane1_write", 32'(led), 32'h0000_3CA5);
        req(1'b1, 4'hF, 32'hBFAF_0000, 32'h0000_A5A5);

        // Switch synchroniser and read-only behaviour
        switch_in = 8'h3C;
        req(1'b0, 4'h0, 32'h0, 32'h0);
        req(1'b0, 4'h0, 32'h0, 32'h0);
        req(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
        check("switch_sync", sram_bus.rdata, 32'h0000_003C);
        req(1'b1, 4'hF, 32'hBFAF_0004, 32'hFFFF_FFFF);
        req(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
        check("switch_ro", sram_bus.rdata, 32'h0000_003C);

        // Timer: write at E0, reads sampled at E2 and E4
        req(1'b1, 4'hF, 32'hBFAF_0008, 32'hFFFF_FFFE);
        req(1'b0, 4'h0, 32'h0, 32'h0);
        req(1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
`ifdef CONF_TIMER_EN
        check("timer_read1", sram_bus.rdata, 32'hFFFF_FFFF);
`else
        check("timer_read1", sram_bus.rdata, 32'h0);
`endif
        req(1'b0, 4'h0, 32'h0, 32'h0);
        req(1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
`ifdef CONF_TIMER_EN
        check("timer_wrap", sram_bus.rdata, 32'h0000_0001);
`else
        check("timer_wrap", sram_bus.rdata, 32'h0);
`endif

        // Mid-stream asynchronous reset
        req(1'b1, 4'hF, 32'h0000_0100, 32'hCAFE_F00D);
        req(1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
        check("pre_reset_rdata", sram_bus.rdata, 32'h0000_A5A5);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_rdata", sram_bus.rdata, 32'h0);
        check("async_reset_led", 32'(led), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        req(1'b1, 4'h0, 32'h0000_0100, 32'h0);
        check("ram_survives_reset", sram_bus.rdata, 32'hCAFE_F00D);
        req(1'b1, 4'h0, 32'hBFAF_000C, 32'h0);
        check("scratch_reset", sram_bus.rdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
